shift_seq_unit: RTL and testbench

- Multi-cycle shifter stage directly downstream of the shifter-input selection mux in the multicycle CPU datapath.
- Captures the selected 32-bit operand and a shift amount, then shifts one bit position per clock.
- Presents the result with a one-cycle done pulse, so the control FSM can sequence shift instructions (sll, srl, sra, sllv, srlv, srav).

---
 rtl/shift_seq_unit.sv | 110 +++++++++++
 tb/tb_shift_seq_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// Bit-serial shifter: loads an operand, then shifts it one position per clock (SLL/SRL/SRA, ROR with SHIFT_SEQ_ROTATE_EN).
// Latency: done pulses 1 cycle after start for shamt==0/NOP, else shamt+1 cycles; start is accepted only while idle.
// Backpressure: none; start raised while busy or done is ignored, not queued.
module shift_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  state_t             state;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic               op_legal;
  logic [WIDTH-1:0]   step_val;

  // Only legal shift ops enter SHIFT; everything else behaves as a load.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:                 op_legal = 1'b1;
`endif
      default:                op_legal = 1'b0;
    endcase
  end

  always_comb begin
    step_val = data_out;
    case (op_q)
      OP_SLL:  step_val = {data_out[WIDTH-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, data_out[WIDTH-1:1]};
      OP_SRA:  step_val = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  step_val = {data_out[0], data_out[WIDTH-1:1]};
`endif
      default: step_val = data_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data_out <= '0;
      count    <= '0;
      op_q     <= OP_NOP;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            data_out <= data_in;
            op_q     <= op;
            count    <= shamt;
            if (shamt == '0 || !op_legal) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_out <= step_val;
          count    <= count - SHAMT_W'(1);
          // The step taken with one position left is the last one.
          if (count == SHAMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: directed cases plus randomized operations checked against an arithmetic model.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  shift_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ecyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = '0;

  function automatic bit is_legal(input logic [2:0] o);
`ifdef SHIFT_SEQ_ROTATE_EN
    return (o >= 3'd1 && o <= 3'd4);
`else
    return (o >= 3'd1 && o <= 3'd3);
`endif
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input int sh);
    if (!is_legal(o)) return d;
    case (o)
      3'd1:    return d << sh;
      3'd2:    return d >> sh;
      3'd3:    return 32'($signed(d) >>> sh);
      3'd4:    return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input int sh);
    return (is_legal(o) && sh != 0) ? sh + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, ecyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and retires scoreboard entries.
  always @(posedge clk) begin
    exp_t e;
    #1;
    ecyc++;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("busy_with_done", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(ecyc), 32'(e.cyc));
          check("result", data_out, e.res);
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
        end
        busy_cnt = 0;
      end else if (exp_q.size() > 0 && ecyc >= exp_q[0].cyc) begin
        e = exp_q.pop_front();
        check("missing_done", 32'd0, 32'd1);
        busy_cnt = 0;
      end
    end
  end

  // Entry point is a negedge where the DUT is in DONE (or IDLE); exits on the negedge where done is visible.
  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input int sh,
                        input bit pulse_mid, input bit junk_in_done,
                        input bit chk_const, input logic [31:0] want);
    exp_t e;
    int   guard;
    start   = junk_in_done;
    op      = 3'($urandom_range(1, 3));
    data_in = ~last_res;
    shamt   = 5'($urandom);
    @(negedge clk);
    check("hold_result", data_out, last_res);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = 5'(sh);
    e.res   = model(o, d, sh);
    e.lat   = model_lat(o, sh);
    e.cyc   = ecyc + e.lat;
    exp_q.push_back(e);
    @(negedge clk);
    guard = 0;
    while (ecyc < e.cyc && guard < 40) begin
      start   = pulse_mid && ($urandom_range(0, 2) == 0);
      op      = 3'($urandom);
      data_in = pulse_mid ? 32'h1234_5678 : $urandom;
      shamt   = 5'($urandom);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (chk_const) check("directed_value", data_out, want);
    last_res = e.res;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = '0;
    data_in = '0;
    shamt   = '0;
    #12;
    check("rst_data_out", data_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Abort a shift with reset: no done pulse, outputs cleared, stays idle.
    start = 1'b1; op = 3'd1; data_in = 32'h0000_0001; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_data_out", data_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_data", data_out, 32'd0);
    last_res = '0;

    run_op(3'd1, 32'h0000_0001, 4,  1'b0, 1'b0, 1'b1, 32'h0000_0010);
    run_op(3'd3, 32'h8000_0000, 31, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 31, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    run_op(3'd1, 32'hFFFF_FFFF, 31, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
    run_op(3'd2, 32'hDEAD_BEEF, 0,  1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    run_op(3'd7, 32'hDEAD_BEEF, 0,  1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_op(3'd2, 32'hF000_0000, 8,  1'b1, 1'b0, 1'b1, 32'h00F0_0000);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(3'd4, 32'h0000_000F, 4,  1'b0, 1'b1, 1'b1, 32'hF000_0000);
`else
    run_op(3'd4, 32'h0000_000F, 4,  1'b0, 1'b1, 1'b1, 32'h0000_000F);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  ro;
      logic [31:0] rd;
      int          rs;
      ro = 3'($urandom);
      rd = $urandom;
      case ($urandom_range(0, 5))
        0:       rs = 0;
        1:       rs = 31;
        default: rs = $urandom_range(0, 31);
      endcase
      run_op(ro, rd, rs, 1'($urandom), 1'($urandom), 1'b0, 32'd0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
